// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, parser states and field-size helpers for the UART command packer.
package uart_cmd_pkg;

  localparam logic [7:0] uart_cmd_write_op = 8'h01;
  localparam logic [7:0] uart_cmd_read_op  = 8'h02;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StSend} uart_cmd_state_e;

  // Address field rounds up to whole bytes on the wire.
  function automatic int unsigned addr_bytes(input int unsigned addr_width);
    return (addr_width + 7) / 8;
  endfunction

  function automatic int unsigned data_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/uart_cmd_packer.sv
// Parses UART RX bytes into framed read/write host commands with an inter-byte timeout.
module uart_cmd_packer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned addr_width_p     = 28,
  parameter int unsigned data_width_p     = 64,
  parameter int unsigned timeout_cycles_p = 30000
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    byte_v_i,
  input  logic [7:0]              byte_i,
  output logic                    byte_yumi_o,
  output logic                    cmd_v_o,
  input  logic                    cmd_ready_and_i,
  output logic                    cmd_write_o,
  output logic [addr_width_p-1:0] cmd_addr_o,
  output logic [data_width_p-1:0] cmd_data_o,
  output logic                    err_opcode_o,
  output logic                    err_timeout_o
);

  localparam int unsigned AddrBytes = addr_bytes(addr_width_p);
  localparam int unsigned DataBytes = data_bytes(data_width_p);
  localparam int unsigned AddrPadW  = AddrBytes * 8;
  localparam int unsigned MaxBytes  = (AddrBytes > DataBytes) ? AddrBytes : DataBytes;
  localparam int unsigned CntW      = $clog2(MaxBytes + 1);
  localparam int unsigned TmoW      = $clog2(timeout_cycles_p + 1);

  localparam logic [CntW-1:0] AddrLast = CntW'(AddrBytes - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DataBytes - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(timeout_cycles_p - 1);

  uart_cmd_state_e         state_q, state_d;
  logic                    write_q, write_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [data_width_p-1:0] data_q, data_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    err_opcode_q, err_opcode_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    accept;

  assign accept = byte_v_i & (state_q != StSend);

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    tmo_d         = '0;
    err_opcode_d  = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (byte_i == uart_cmd_write_op || byte_i == uart_cmd_read_op) begin
            write_d = (byte_i == uart_cmd_write_op);
            addr_d  = '0;
            data_d  = '0;
            cnt_d   = '0;
            state_d = StAddr;
          end else begin
            err_opcode_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (accept) begin
          // Lanes start cleared, so OR-ing in the shifted byte fills one lane; bits past
          // addr_width_p fall off in the truncating cast.
          addr_d = addr_q | addr_width_p'(AddrPadW'(byte_i) << (8 * cnt_q));
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == AddrLast) begin
            cnt_d   = '0;
            state_d = write_q ? StData : StSend;
          end
        end else if (tmo_q == TmoLast) begin
          state_d       = StIdle;
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StData: begin
        if (accept) begin
          data_d = data_q | (data_width_p'(byte_i) << (8 * cnt_q));
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == DataLast) begin
            cnt_d   = '0;
            state_d = StSend;
          end
        end else if (tmo_q == TmoLast) begin
          state_d       = StIdle;
          err_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StSend: begin
        if (cmd_ready_and_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign byte_yumi_o   = accept;
  assign cmd_v_o       = (state_q == StSend);
  assign cmd_write_o   = write_q;
  assign cmd_addr_o    = addr_q;
  assign cmd_data_o    = data_q;
  assign err_opcode_o  = err_opcode_q;
  assign err_timeout_o = err_timeout_q;

endmodule
